// File: rtl/control_pipeline.sv
// control_pipeline: ID-stage decode for the 8-bit pipelined core, with MEM/WB control
// pipeline registers, stall/flush bubbles, sticky halt and a retired-instruction counter.
module control_pipeline #(
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         instruction_IF,
    input  logic                stall,
    input  logic                flush,
    output logic [3:0]          opcode,
    output logic [1:0]          ImmSrc,
    output logic                ALUsrc,
    output logic                dir,
    output logic                is_unsigned,
    output logic                jump,
    output logic                MemRead_MEM,
    output logic                MemWrite_MEM,
    output logic                RegWrite_MEM,
    output logic                ResultSrc_MEM,
    output logic                RegWrite_WB,
    output logic                halted,
    output logic [RETIRE_W-1:0] retired
);
    localparam logic [3:0] OP_SLT   = 4'h5;
    localparam logic [3:0] OP_SHIFT = 4'h6;
    localparam logic [3:0] OP_ADDI  = 4'h7;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_BEQ   = 4'hA;
    localparam logic [3:0] OP_BNE   = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_NOP   = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef struct packed {
        logic valid;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic result_src;
        logic is_halt;
    } s1_t;

    typedef struct packed {
        logic valid;
        logic reg_write;
    } s2_t;

    s1_t                 s1_d, s1_q;
    s2_t                 s2_d, s2_q;
    logic                halted_d, halted_q;
    logic [RETIRE_W-1:0] retired_d, retired_q;
    logic [3:0]          op_eff;
    logic                bubble;

    // Register fields are consumed by the datapath, not by control.
    logic unused_fields;
    assign unused_fields = ^instruction_IF[11:1];

    always_comb begin
        op_eff      = halted_q ? OP_NOP : instruction_IF[15:12];
        opcode      = op_eff;
        ImmSrc      = (op_eff == OP_ADDI || op_eff == OP_LOAD) ? 2'b01 :
                      (op_eff == OP_STORE) ? 2'b10 :
                      (op_eff inside {OP_BEQ, OP_BNE, OP_JMP}) ? 2'b11 : 2'b00;
        ALUsrc      = op_eff inside {OP_ADDI, OP_LOAD, OP_STORE};
        dir         = (op_eff == OP_SHIFT) & instruction_IF[0];
        is_unsigned = (op_eff == OP_SLT) & instruction_IF[0];
        jump        = (op_eff == OP_JMP) & ~stall & ~flush & ~halted_q;
        bubble      = stall | flush | halted_q;
        s1_d        = bubble ? '0 : s1_t'{
                          valid:      1'b1,
                          mem_read:   op_eff == OP_LOAD,
                          mem_write:  op_eff == OP_STORE,
                          reg_write:  op_eff <= OP_LOAD,
                          result_src: op_eff == OP_LOAD,
                          is_halt:    op_eff == OP_HALT};
        s2_d        = s2_t'{valid: s1_q.valid, reg_write: s1_q.reg_write};
        halted_d    = halted_q | (s1_q.valid & s1_q.is_halt);
        retired_d   = retired_q + RETIRE_W'(s2_q.valid);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    assign MemRead_MEM   = s1_q.mem_read;
    assign MemWrite_MEM  = s1_q.mem_write;
    assign RegWrite_MEM  = s1_q.reg_write;
    assign ResultSrc_MEM = s1_q.result_src;
    assign RegWrite_WB   = s2_q.reg_write;
    assign halted        = halted_q;
    assign retired       = retired_q;
endmodule

// File: tb/tb_control_pipeline.sv
// tb_control_pipeline: directed vectors push hand-computed responses into a queue;
// a negedge monitor pops and compares them against the DUT each cycle.
module tb_control_pipeline;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instruction_IF = 16'hE000;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  opcode;
    logic [1:0]  ImmSrc;
    logic        ALUsrc, dir, is_unsigned, jump;
    logic        MemRead_MEM, MemWrite_MEM, RegWrite_MEM, ResultSrc_MEM;
    logic        RegWrite_WB, halted;
    logic [15:0] retired;

    int nvec = 0;
    int nbad = 0;
    logic [31:0] exp_q[$];
    int          id_q[$];

    control_pipeline #(.RETIRE_W(16)) dut (
        .clk(clk), .reset(reset), .instruction_IF(instruction_IF),
        .stall(stall), .flush(flush), .opcode(opcode), .ImmSrc(ImmSrc),
        .ALUsrc(ALUsrc), .dir(dir), .is_unsigned(is_unsigned), .jump(jump),
        .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
        .RegWrite_MEM(RegWrite_MEM), .ResultSrc_MEM(ResultSrc_MEM),
        .RegWrite_WB(RegWrite_WB), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    // idf = {ALUsrc, dir, is_unsigned, jump}; mem = {MemRead, MemWrite, RegWrite, ResultSrc}
    task automatic vec(input logic [15:0] ins, input logic st, input logic fl, input logic rs,
                       input logic [3:0] op, input logic [1:0] imm, input logic [3:0] idf,
                       input logic [3:0] mem, input logic rwb, input logic hlt,
                       input logic [15:0] ret);
        instruction_IF = ins;
        stall = st;
        flush = fl;
        reset = rs;
        exp_q.push_back({op, imm, idf, mem, rwb, hlt, ret});
        id_q.push_back(nvec);
        nvec++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [31:0] act, expv;
            int id;
            act = {opcode, ImmSrc, ALUsrc, dir, is_unsigned, jump, MemRead_MEM, MemWrite_MEM,
                   RegWrite_MEM, ResultSrc_MEM, RegWrite_WB, halted, retired};
            expv = exp_q.pop_front();
            id = id_q.pop_front();
            if (act !== expv) begin
                nbad++;
                if (nbad <= 50)
                    $display("FAIL vec%0d ins=%h: got op=%h imm=%b idf=%b mem=%b wb=%b hlt=%b ret=%h, want op=%h imm=%b idf=%b mem=%b wb=%b hlt=%b ret=%h",
                             id, instruction_IF, act[31:28], act[27:26], act[25:22], act[21:18], act[17],
                             act[16], act[15:0], expv[31:28], expv[27:26], expv[25:22], expv[21:18],
                             expv[17], expv[16], expv[15:0]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        // reset, LOAD flow, stall bubble
        vec(16'hE000, 0, 0, 1, 4'hE, 2'd0, 4'b0000, 4'b0000, 0, 0, 16'd0);
        vec(16'h8240, 0, 0, 0, 4'h8, 2'd1, 4'b1000, 4'b0000, 0, 0, 16'd0);
        vec(16'hE000, 0, 0, 0, 4'hE, 2'd0, 4'b0000, 4'b1011, 0, 0, 16'd0);
        vec(16'h0000, 1, 0, 0, 4'h0, 2'd0, 4'b0000, 4'b0000, 1, 0, 16'd0);
        vec(16'h0000, 0, 0, 0, 4'h0, 2'd0, 4'b0000, 4'b0000, 0, 0, 16'd1);
        // branch then flushed ADDI
        vec(16'hA000, 0, 0, 0, 4'hA, 2'd3, 4'b0000, 4'b0010, 0, 0, 16'd2);
        vec(16'h7245, 0, 1, 0, 4'h7, 2'd1, 4'b1000, 4'b0000, 1, 0, 16'd2);
        vec(16'hE000, 0, 0, 0, 4'hE, 2'd0, 4'b0000, 4'b0000, 0, 0, 16'd3);
        // JMP with and without stall
        vec(16'hC0F0, 0, 0, 0, 4'hC, 2'd3, 4'b0001, 4'b0000, 0, 0, 16'd4);
        vec(16'hC0F0, 1, 0, 0, 4'hC, 2'd3, 4'b0000, 4'b0000, 0, 0, 16'd4);
        // SHIFT dir, SLT unsigned, STORE
        vec(16'h6001, 0, 0, 0, 4'h6, 2'd0, 4'b0100, 4'b0000, 0, 0, 16'd5);
        vec(16'h5001, 0, 0, 0, 4'h5, 2'd0, 4'b0010, 4'b0010, 0, 0, 16'd6);
        vec(16'h9000, 0, 0, 0, 4'h9, 2'd2, 4'b1000, 4'b0010, 1, 0, 16'd6);
        // HALT then ADD stream: one ADD slips in before halted takes effect
        vec(16'hF000, 0, 0, 0, 4'hF, 2'd0, 4'b0000, 4'b0100, 1, 0, 16'd7);
        vec(16'h0000, 0, 0, 0, 4'h0, 2'd0, 4'b0000, 4'b0000, 0, 0, 16'd8);
        vec(16'h0000, 0, 0, 0, 4'hE, 2'd0, 4'b0000, 4'b0010, 0, 1, 16'd9);
        vec(16'h0000, 0, 0, 0, 4'hE, 2'd0, 4'b0000, 4'b0000, 1, 1, 16'd10);
        vec(16'h0000, 0, 0, 0, 4'hE, 2'd0, 4'b0000, 4'b0000, 0, 1, 16'd11);
        vec(16'hC0F0, 0, 0, 0, 4'hE, 2'd0, 4'b0000, 4'b0000, 0, 1, 16'd11);
        vec(16'h0000, 0, 0, 1, 4'h0, 2'd0, 4'b0000, 4'b0000, 0, 0, 16'd0);
        vec(16'h0000, 0, 0, 0, 4'h0, 2'd0, 4'b0000, 4'b0000, 0, 0, 16'd0);
        // counter wrap: 65535 NOPs retire, then the STORE takes it to 0
        vec(16'hE000, 0, 0, 1, 4'hE, 2'd0, 4'b0000, 4'b0000, 0, 0, 16'd0);
        for (int t = 0; t <= 65538; t++) begin
            logic st_id;
            st_id = (t == 65535);
            vec(st_id ? 16'h9000 : 16'hE000, 0, 0, 0, st_id ? 4'h9 : 4'hE,
                st_id ? 2'd2 : 2'd0, st_id ? 4'b1000 : 4'b0000,
                (t == 65536) ? 4'b0100 : 4'b0000, 0, 0, (t < 2) ? 16'd0 : 16'(t - 2));
        end
        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            nbad++;
            $display("FAIL drain: %0d expected responses never checked", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/control_pipeline.md
Name: control_pipeline

Overview:
- Main control unit for the 8-bit pipelined core.
- Decodes the 16-bit fetched instruction into ID-stage control signals, which the datapath registers into its EX latch.
- Carries memory and writeback controls through two internal pipeline registers so they stay aligned with the datapath's MEM and WB stages.
- Handles stall bubbles, flush, sticky halt and a retired-instruction counter.

Parameters:
- RETIRE_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instruction_IF  in  16  instruction currently in ID; opcode=[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3].
- stall  in  1  load-use stall from hazard detection.
- flush  in  1  mispredict flush from the control-hazard unit.
- opcode  out  4  instruction_IF[15:12], forced to 4'hE (NOP) when halted.
- ImmSrc  out  2  00 none, 01 I-type imm[5:0] sign-extended, 10 store imm, 11 jump/branch imm[7:0].
- ALUsrc  out  1  1 = immediate operand.
- dir  out  1  shift direction, instruction_IF[0] for SHIFT, else 0.
- is_unsigned  out  1  instruction_IF[0] for SLT, else 0.
- jump  out  1  ID-stage JMP redirect.
- MemRead_MEM  out  1  stage-1 register.
- MemWrite_MEM  out  1  stage-1 register.
- RegWrite_MEM  out  1  stage-1 register.
- ResultSrc_MEM  out  1  stage-1 register; 1 = memory data.
- RegWrite_WB  out  1  stage-2 register.
- halted  out  1  sticky halt flag.
- retired  out  RETIRE_W  count of valid instructions that left stage 2.

Behaviour:
- Opcode map (fixed):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SHIFT: RegWrite=1, ALUsrc=0, ImmSrc=00.
  - 7 ADDI: RegWrite=1, ALUsrc=1, ImmSrc=01.
  - 8 LOAD: MemRead=1, RegWrite=1, ResultSrc=1, ALUsrc=1, ImmSrc=01.
  - 9 STORE: MemWrite=1, ALUsrc=1, ImmSrc=10.
  - A BEQ, B BNE: ImmSrc=11, no writes.
  - C JMP: ImmSrc=11, jump=1.
  - D reserved, treated as NOP.
  - E NOP: all controls 0.
  - F HALT: all controls 0; sets halted when latched into stage 1.
- ID outputs are combinational from instruction_IF and halted.
- jump = (opcode==C) & !stall & !flush & !halted.
- Stage 1 (S1) holds {valid, MemRead, MemWrite, RegWrite, ResultSrc, is_halt}.
  - Each cycle S1 loads the decoded bundle.
  - S1 loads a bubble (all zeros) instead when stall, flush or halted is 1.
  - Stall and flush together: bubble.
- Stage 2 (S2) holds {valid, RegWrite}.
  - S2 always advances from S1, regardless of stall or flush.
- halted:
  - Set on the cycle after S1 captures a valid HALT.
  - Cleared only by reset.
  - While halted, ID outputs read as NOP and S1 receives bubbles; instructions already in S1/S2 drain normally.
- retired:
  - Increments by 1 on each edge where S2.valid=1.
  - Wraps from 2^RETIRE_W-1 to 0.
  - Bubbles are not counted; HALT is counted.
- Latency: ID controls at 0 cycles; *_MEM outputs 1 cycle after the ID cycle; RegWrite_WB 2 cycles after the ID cycle.
- Reset, asynchronous, may occur mid-operation: S1, S2, halted and retired all clear to 0. All registered outputs read 0 during and immediately after reset.

Test Plan:
- LOAD r1 (16'h8240) in ID for 1 cycle, then NOP -> next cycle MemRead_MEM=1, RegWrite_MEM=1, ResultSrc_MEM=1; cycle after that RegWrite_WB=1; retired increments from 0 to 1 one cycle later.
- ADD with stall=1 for 1 cycle -> *_MEM all 0 that cycle (bubble); retired does not increment for the bubble.
- BEQ in ID, then flush=1 while ADDI (16'h7245) in ID -> ADDI never sets RegWrite_MEM; ImmSrc=01 and ALUsrc=1 still visible combinationally during the flush cycle.
- JMP (16'hC0F0) with stall=0 -> jump=1, ImmSrc=11. Same instruction with stall=1 -> jump=0.
- HALT (16'hF000) followed by ADD stream -> halted=1 one cycle after S1 capture; opcode reads 4'hE afterwards; retired stops after HALT retires; asserting reset clears halted and retired to 0.
- Preload retired to 16'hFFFF (via sequence or force) and retire STORE -> retired=16'h0000; RegWrite_WB=0 for STORE.
